// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with manual modes and an MSB-first serial burst engine
module univ_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             d,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, up, down;
  logic done_q, done_d;
  assign up = {sr_q[WIDTH-2:0], rot ? sr_q[WIDTH-1] : d};
  assign down = {rot ? sr_q[0] : d, sr_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    done_d = 1'b0;
    if (state_q == BURST) begin
      sr_d = {sr_q[WIDTH-2:0], d};
      cnt_d = CW'(cnt_q + 1'b1);
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = IDLE;
        cnt_d = '0;
        done_d = 1'b1;
      end
    end else if (start) begin
      sr_d = par_in;
      cnt_d = '0;
      state_d = BURST;
    end else if (en) begin
      sr_d = mode == 2'b01 ? up : mode == 2'b10 ? down : mode == 2'b11 ? par_in : sr_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      done_q <= done_d;
    end
  end
  assign q = sr_q;
  assign ser_out = sr_q[WIDTH-1];
  assign busy = state_q == BURST;
  assign done = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed plus random checks of univ_shift_reg against an arithmetic reference model
module tb_univ_shift_reg;
  localparam int W = 4;
  logic clk = 0, reset = 0, en = 0, rot = 0, d = 0, start = 0;
  logic [1:0] mode = 0;
  logic [W-1:0] par_in = 0;
  logic [W-1:0] q;
  logic ser_out, busy, done;
  int n_assert = 0, n_fail = 0;
  int m_q = 0, m_left = 0, m_done = 0;
  always #5 clk = ~clk;
  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .rot(rot), .d(d),
    .par_in(par_in), .start(start), .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check(string tag);
    chk({tag, " q"}, 32'(q), 32'(m_q));
    chk({tag, " ser_out"}, 32'(ser_out), 32'(m_q / (2 ** (W - 1))));
    chk({tag, " busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, " done"}, 32'(done), 32'(m_done));
  endtask
  task automatic model_reset;
    m_q = 0;
    m_left = 0;
    m_done = 0;
  endtask
  task automatic model_edge;
    int top, full;
    full = 2 ** W;
    top = 2 ** (W - 1);
    if (m_left > 0) begin
      m_q = (m_q * 2 + int'(d)) % full;
      m_left--;
      m_done = m_left == 0;
    end else begin
      m_done = 0;
      if (start) begin
        m_q = int'(par_in);
        m_left = W;
      end else if (en) begin
        if (mode == 1) m_q = (m_q * 2 + (rot ? m_q / top : int'(d))) % full;
        else if (mode == 2) m_q = m_q / 2 + (rot ? m_q % 2 : int'(d)) * top;
        else if (mode == 3) m_q = int'(par_in);
      end
    end
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check(tag);
  endtask
  task automatic async_reset(string tag);
    #2 reset = 0;
    #1 model_reset();
    check(tag);
    #2 reset = 1;
  endtask
  initial begin
    #2 model_reset();
    check("reset");
    #10 reset = 1;
    en = 1; mode = 2'b01; rot = 0; d = 1;
    repeat (4) tick("shift_up_d");
    chk("shift_up_final", 32'(q), 32'hf);
    mode = 2'b11; par_in = 4'b1000;
    tick("load_1000");
    mode = 2'b01; rot = 1;
    repeat (4) tick("rot_up");
    chk("rot_up_final", 32'(q), 32'h8);
    mode = 2'b10;
    tick("rot_down");
    chk("rot_down_final", 32'(q), 32'h4);
    en = 0; mode = 2'b11; par_in = 4'b0110;
    tick("en0_hold");
    chk("en0_q", 32'(q), 32'h4);
    en = 1;
    tick("en1_load");
    chk("en1_q", 32'(q), 32'h6);
    en = 0; mode = 0; rot = 0; d = 0; par_in = 4'b1011; start = 1;
    tick("burst_start");
    start = 0;
    repeat (4) tick("burst");
    chk("burst_done", 32'(done), 32'h1);
    chk("burst_q", 32'(q), 32'h0);
    tick("after_done");
    par_in = 4'b0011; start = 1;
    tick("burst2_start");
    d = 1; tick("burst2_d1");
    d = 1; tick("burst2_d2");
    d = 0; tick("burst2_d3");
    d = 1; tick("burst2_d4");
    chk("burst2_q", 32'(q), 32'hd);
    tick("back_to_back");
    chk("back_to_back_busy", 32'(busy), 32'h1);
    start = 0;
    repeat (4) tick("burst3");
    par_in = 4'b0101; start = 1;
    tick("burst4_start");
    start = 0;
    repeat (2) tick("burst4");
    async_reset("mid_burst_reset");
    chk("mid_burst_busy", 32'(busy), 32'h0);
    tick("post_reset");
    start = 1; par_in = 4'b1001;
    tick("burst5_start");
    start = 0;
    repeat (5) tick("burst5");
    repeat (400) begin
      en = 1'($urandom); rot = 1'($urandom); d = 1'($urandom);
      mode = 2'($urandom); par_in = W'($urandom);
      start = $urandom_range(0, 5) == 0;
      tick("random");
      if ($urandom_range(0, 49) == 0) async_reset("random_reset");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH SHALL default to 4; register width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 en  in  1  enables the manual mode operation for the current cycle.
REQ-006 mode  in  2  manual operation: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
REQ-007 rot  in  1  1 makes shift up/down rotate instead of taking d.
REQ-008 d  in  1  serial data input.
REQ-009 par_in  in  WIDTH  parallel load and burst source data.
REQ-010 start  in  1  single-cycle request to begin a WIDTH-bit serial burst.
REQ-011 q  out  WIDTH  register contents.
REQ-012 ser_out  out  1  serial output, always equal to q[WIDTH-1].
REQ-013 busy  out  1  high while a burst is in progress.
REQ-014 done  out  1  one-cycle pulse when a burst completes.

Function
REQ-015 Shift up SHALL set q[0] <= d (or q[WIDTH-1] if rot) and q[i] <= q[i-1] for i >= 1.
REQ-016 Shift down SHALL set q[WIDTH-1] <= d (or q[0] if rot) and q[i] <= q[i+1] for i < WIDTH-1.
REQ-017 Parallel load SHALL set q <= par_in; rot is ignored.
REQ-018 Hold, or en=0 while IDLE, SHALL leave q unchanged.
REQ-019 The FSM SHALL have two states, IDLE and BURST, plus a bit counter of clog2(WIDTH) bits.
REQ-020 In IDLE with start=1, the next edge SHALL load q <= par_in, clear the counter, and enter BURST; start has priority over en/mode.
REQ-021 In BURST, every edge SHALL perform a shift up with d, regardless of en, mode, and rot, and SHALL increment the counter.
REQ-022 The edge with counter == WIDTH-1 SHALL perform the final shift and return to IDLE; busy is therefore high for exactly WIDTH cycles.
REQ-023 During burst cycle j (j=0..WIDTH-1), ser_out SHALL present par_in[WIDTH-1-j], MSB first.
REQ-024 At burst end, q SHALL hold the WIDTH d bits sampled during the burst, with the first-sampled bit at q[WIDTH-1].
REQ-025 done SHALL be high for exactly the one cycle after the return-to-IDLE edge.
REQ-026 start while BURST SHALL be ignored; there is no queueing.
REQ-027 start in the cycle done is high SHALL begin a new burst normally; there are no idle cycles between bursts.
REQ-028 All outputs SHALL be registered or be direct functions of registers; there is no combinational path from inputs to outputs.

Reset
REQ-029 reset=0 SHALL asynchronously force q=0, ser_out=0, busy=0, done=0, counter=0, and state=IDLE.
REQ-030 A reset asserted mid-burst SHALL abort the burst without a done pulse; after release the block is IDLE.
REQ-031 The first active edge after reset release SHALL act normally, with no extra latency.

Verification
REQ-032 WIDTH=4, reset, d=1, en=1, mode=01, rot=0 for 4 edges -> q: 0001, 0011, 0111, 1111.
REQ-033 q=1000, mode=01, rot=1 for 4 edges -> 0001, 0010, 0100, 1000; mode=10, rot=1 from 1000 -> 0100.
REQ-034 par_in=1011, start pulse, d held 0 -> busy high 4 cycles, ser_out 1,0,1,1, then done for one cycle, q=0000.
REQ-035 Burst with d sequence 1,1,0,1 -> final q=1101; start held high during the burst changes nothing; start in the done cycle -> busy reasserts on the next edge.
REQ-036 reset=0 asserted between edges during the 3rd burst cycle -> q=0 and busy=0 immediately, no done pulse; next start works normally.
REQ-037 en=0 with mode=11, then en=1 with mode=11 and par_in=0110 -> q unchanged for the first edge, then q=0110.
